// File: rtl/dma_reg_rr_arbiter.sv
// Round-robin arbiter sharing one register-interface bridge among NumReq requesters.
// A grant stays locked for the whole transaction; an optional watchdog forces an error response.

package dma_reg_rr_arbiter_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

// state | meaning
// IDLE  | no grant; scanning requesters upward from rr_q
// BUSY  | gnt_q owns the bridge until completion, abandon or timeout
module dma_reg_rr_arbiter #(
  parameter int unsigned NumReq        = 2,
  parameter type         reg_req_t     = dma_reg_rr_arbiter_pkg::reg_req_t,
  parameter type         reg_rsp_t     = dma_reg_rr_arbiter_pkg::reg_rsp_t,
  parameter int unsigned TimeoutCycles = 1024,
  localparam int unsigned IdxW         = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  reg_req_t        in_req_i [NumReq],
  output reg_rsp_t        in_rsp_o [NumReq],
  output reg_req_t        out_req_o,
  input  reg_rsp_t        out_rsp_i,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic            busy_o,
  output logic            timeout_o
);

  localparam int unsigned CntW    = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam int unsigned TmoLast = (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;
  localparam logic [CntW-1:0] CntLast = CntW'(TmoLast);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          state_q;
  logic [IdxW-1:0] rr_q;
  logic [IdxW-1:0] gnt_q;
  logic [CntW-1:0] cnt_q;

  logic [IdxW-1:0] cand;
  logic [IdxW-1:0] hit_idx;
  logic [IdxW-1:0] next_rr;
  logic            hit;
  logic            gnt_valid;
  logic            tmo;
  logic            done;

  // First valid requester at or above rr_q, wrapping around.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    cand    = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = IdxW'((32'(rr_q) + i) % NumReq);
      if (!hit && in_req_i[cand].valid) begin
        hit     = 1'b1;
        hit_idx = cand;
      end
    end
  end

  assign next_rr   = (32'(gnt_q) == NumReq - 1) ? '0 : gnt_q + 1'b1;
  assign gnt_valid = in_req_i[gnt_q].valid;
  // Completion beats the watchdog; an abandoned request gets no forced response.
  assign tmo  = (TimeoutCycles > 0) && (state_q == BUSY) && gnt_valid &&
                !out_rsp_i.ready && (cnt_q == CntLast);
  assign done = !gnt_valid || out_rsp_i.ready || tmo;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit) begin
            state_q <= BUSY;
            gnt_q   <= hit_idx;
            cnt_q   <= '0;
          end
        end
        BUSY: begin
          if (done) begin
            state_q <= IDLE;
            rr_q    <= next_rr;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    out_req_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      in_rsp_o[i] = '0;
    end
    timeout_o = tmo;
    if (state_q == BUSY) begin
      out_req_o       = in_req_i[gnt_q];
      in_rsp_o[gnt_q] = out_rsp_i;
      if (tmo) begin
        out_req_o.valid       = 1'b0;
        in_rsp_o[gnt_q]       = '0;
        in_rsp_o[gnt_q].ready = 1'b1;
        in_rsp_o[gnt_q].error = 1'b1;
      end
    end
  end

  assign busy_o    = (state_q == BUSY);
  assign gnt_idx_o = gnt_q;

endmodule
